// File: rtl/arb_pkg.sv
// Shared helpers and types for the priority round-robin arbiter.
package arb_pkg;

    localparam int DEF_PRIO_W = 3;

    // The effective priority carries one extra MSB, which is the aged flag.
    typedef logic [DEF_PRIO_W:0] eff_prio_t;

    // The pointer resets to one below channel 0 (mod NUM_CH), so ch0 is favoured first.
    localparam int RR_PTR_RST_OFS = 1;

    function automatic int ch_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational finder: picks the highest effective priority among the requesters.
// Ties go to the first requester found cyclically after the pointer.
module rr_pick
    import arb_pkg::*;
#(
    parameter  int NUM_CH = 8,
    parameter  int EP_W   = 4,
    localparam int CW     = ch_idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0]           req,
    input  logic [NUM_CH-1:0][EP_W-1:0] prio,
    input  logic [CW-1:0]               ptr,
    output logic [CW-1:0]               win,
    output logic                        any
);

    logic [EP_W-1:0] best;
    int              j;

    // Walk from ptr+1 in cyclic order. The strict '>' keeps the earliest tie.
    always_comb begin
        win  = '0;
        any  = 1'b0;
        best = '0;
        j    = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (req[j] && (!any || prio[j] > best)) begin
                any  = 1'b1;
                best = prio[j];
                win  = CW'(j);
            end
        end
    end

endmodule

// File: rtl/prio_rr_arbiter.sv
// N-channel valid/ready arbiter with a registered output stage. Priority selects the winner.
// Equal priorities are broken round-robin. Aging is enabled by PRIO_RR_ARBITER_AGING_EN.
module prio_rr_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_CH    = 8,
    parameter int DATA_W    = 32,
    parameter int PRIO_W    = 3,
    parameter int AGE_LIMIT = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          valid_i,
    input  logic [NUM_CH*DATA_W-1:0]   data_i,
    input  logic [NUM_CH*PRIO_W-1:0]   priority_i,
    output logic [NUM_CH-1:0]          ready_i,
    output logic                       valid_o,
    output logic [DATA_W-1:0]          data_o,
    output logic [$clog2(NUM_CH)-1:0]  chan_o,
    input  logic                       ready_o
);

    localparam int CW      = ch_idx_w(NUM_CH);
    localparam int EP_W    = PRIO_W + 1;
    localparam int PTR_RST = NUM_CH - RR_PTR_RST_OFS;

    if (NUM_CH < 2 || AGE_LIMIT < 1) begin : g_bad_param
        $error("prio_rr_arbiter: NUM_CH must be >= 2 and AGE_LIMIT >= 1");
    end

    logic [NUM_CH-1:0][EP_W-1:0] eff;
    logic [CW-1:0]               ptr;
    logic [CW-1:0]               winner;
    logic                        any_valid;
    logic                        load;

    assign load = !valid_o || ready_o;

`ifdef PRIO_RR_ARBITER_AGING_EN
    localparam int AW = $clog2(AGE_LIMIT + 1);
    logic [NUM_CH-1:0][AW-1:0] age;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            age <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!valid_i[k] || ready_i[k])
                    age[k] <= '0;
                else if (age[k] != AW'(AGE_LIMIT))
                    age[k] <= age[k] + AW'(1);
            end
        end
    end
`endif

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
`ifdef PRIO_RR_ARBITER_AGING_EN
        assign eff[k] = {age[k] == AW'(AGE_LIMIT), priority_i[k*PRIO_W +: PRIO_W]};
`else
        assign eff[k] = {1'b0, priority_i[k*PRIO_W +: PRIO_W]};
`endif
        // Gated by reset so that no grant leaks out while the output stage is being cleared.
        assign ready_i[k] = !reset && load && any_valid && (winner == CW'(k));
    end

    rr_pick #(
        .NUM_CH (NUM_CH),
        .EP_W   (EP_W)
    ) u_pick (
        .req    (valid_i),
        .prio   (eff),
        .ptr    (ptr),
        .win    (winner),
        .any    (any_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            chan_o  <= '0;
            ptr     <= CW'(PTR_RST);
        end else if (load) begin
            if (any_valid) begin
                valid_o <= 1'b1;
                data_o  <= data_i[winner*DATA_W +: DATA_W];
                chan_o  <= winner;
                ptr     <= winner;
            end else begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Directed bench for prio_rr_arbiter (8 ch, 5 ch, and 8 ch with AGE_LIMIT=4) and rr_pick.
module tb_prio_rr_arbiter;
    import arb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // main 8-channel instance
    logic [7:0]   valid_m, ready_m;
    logic [255:0] data_m;
    logic [23:0]  prio_m;
    logic         vo_m, ro_m;
    logic [31:0]  do_m;
    logic [2:0]   ch_m;

    // 5-channel instance
    logic [4:0]   valid_5, ready_5;
    logic [159:0] data_5;
    logic [14:0]  prio_5;
    logic         vo_5, ro_5;
    logic [31:0]  do_5;
    logic [2:0]   ch_5;

    // 8-channel instance with a short age limit
    logic [7:0]   valid_a, ready_a;
    logic [255:0] data_a;
    logic [23:0]  prio_a;
    logic         vo_a, ro_a;
    logic [31:0]  do_a;
    logic [2:0]   ch_a;

    // standalone finder
    logic [3:0]      pk_req;
    eff_prio_t [3:0] pk_prio;
    logic [1:0]      pk_ptr, pk_win;
    logic            pk_any;

    int errors = 0;
    int checks = 0;

    prio_rr_arbiter dut (
        .clk(clk), .reset(reset), .valid_i(valid_m), .data_i(data_m), .priority_i(prio_m),
        .ready_i(ready_m), .valid_o(vo_m), .data_o(do_m), .chan_o(ch_m), .ready_o(ro_m)
    );

    prio_rr_arbiter #(.NUM_CH(5)) dut5 (
        .clk(clk), .reset(reset), .valid_i(valid_5), .data_i(data_5), .priority_i(prio_5),
        .ready_i(ready_5), .valid_o(vo_5), .data_o(do_5), .chan_o(ch_5), .ready_o(ro_5)
    );

    prio_rr_arbiter #(.AGE_LIMIT(4)) dut_age (
        .clk(clk), .reset(reset), .valid_i(valid_a), .data_i(data_a), .priority_i(prio_a),
        .ready_i(ready_a), .valid_o(vo_a), .data_o(do_a), .chan_o(ch_a), .ready_o(ro_a)
    );

    rr_pick #(.NUM_CH(4), .EP_W(4)) u_pick (
        .req(pk_req), .prio(pk_prio), .ptr(pk_ptr), .win(pk_win), .any(pk_any)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int k, input logic v, input logic [31:0] d, input logic [2:0] p);
        valid_m[k] = v; data_m[k*32 +: 32] = d; prio_m[k*3 +: 3] = p;
    endtask

    task automatic set_5(input int k, input logic v, input logic [31:0] d, input logic [2:0] p);
        valid_5[k] = v; data_5[k*32 +: 32] = d; prio_5[k*3 +: 3] = p;
    endtask

    task automatic set_a(input int k, input logic v, input logic [31:0] d, input logic [2:0] p);
        valid_a[k] = v; data_a[k*32 +: 32] = d; prio_a[k*3 +: 3] = p;
    endtask

    initial begin
        int seq3 [3] = '{1, 6, 3};
        int seq5 [3] = '{0, 4, 0};
        reset = 1'b1;
        valid_m = '0; data_m = '0; prio_m = '0; ro_m = 1'b0;
        valid_5 = '0; data_5 = '0; prio_5 = '0; ro_5 = 1'b0;
        valid_a = '0; data_a = '0; prio_a = '0; ro_a = 1'b0;

        // rr_pick standalone
        pk_req = 4'b1010; pk_prio = '0; pk_prio[3] = 4'd2; pk_prio[1] = 4'd2; pk_ptr = 2'd1;
        #1 check("pick_tie_p1", {pk_any, pk_win}, {1'b1, 2'd3});
        pk_ptr = 2'd3;
        #1 check("pick_tie_p3", {pk_any, pk_win}, {1'b1, 2'd1});
        pk_req = 4'b0000;
        #1 check("pick_none", pk_any, 1'b0);
        pk_req = 4'b0111; pk_prio = '0; pk_prio[0] = 4'd1; pk_prio[1] = 4'd1; pk_prio[2] = 4'd5; pk_ptr = 2'd2;
        #1 check("pick_high", {pk_any, pk_win}, {1'b1, 2'd2});

        // reset state
        @(negedge clk);
        check("rst_valid", vo_m, 1'b0);
        check("rst_data", do_m, 32'h0);
        check("rst_chan", ch_m, 3'd0);

        // test 1: mid-stream reset
        for (int k = 0; k < 8; k++) set_m(k, 1'b1, 32'h1000_0000 + 32'(k), 3'd0);
        #1 check("t1_rdy_in_rst", ready_m, 8'h00);
        reset = 1'b0;
        #1 check("t1_rdy_first", ready_m, 8'h01);
        tick;
        check("t1_held", {vo_m, ch_m, do_m}, {1'b1, 3'd0, 32'h1000_0000});
        check("t1_rdy_bp", ready_m, 8'h00);
        #2 reset = 1'b1;
        #1 check("t1_async", {vo_m, do_m, ready_m}, {1'b0, 32'h0, 8'h00});
        #2 reset = 1'b0;
        #1 check("t1_rdy_after", ready_m, 8'h01);

        // test 2: equal priority, full throughput
        ro_m = 1'b1;
        for (int c = 0; c < 9; c++) begin
            check("t2_rdy", ready_m, 8'(1) << (c % 8));
            tick;
            check("t2_out", {vo_m, ch_m, do_m}, {1'b1, 3'(c % 8), 32'h1000_0000 + 32'(c % 8)});
        end

        // test 3: mixed priority
        valid_m = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        set_m(1, 1'b1, 32'h3000_0001, 3'd7);
        set_m(6, 1'b1, 32'h3000_0006, 3'd7);
        set_m(3, 1'b1, 32'h3000_0003, 3'd5);
        for (int c = 0; c < 3; c++) begin
            #1 check("t3_rdy", ready_m, 8'(1) << seq3[c]);
            tick;
            check("t3_out", {vo_m, ch_m}, {1'b1, 3'(seq3[c])});
            set_m(seq3[c], 1'b0, 32'h0, 3'd0);
        end
        #1 check("t3_rdy_idle", ready_m, 8'h00);
        tick;
        check("t3_drain", {vo_m, ch_m, do_m}, {1'b0, 3'd3, 32'h3000_0003});

        // test 4: backpressure
        ro_m = 1'b0;
        set_m(2, 1'b1, 32'hA5A5_A5A5, 3'd2);
        #1 check("t4_rdy_load", ready_m, 8'h04);
        tick;
        set_m(2, 1'b0, 32'h0, 3'd0);
        set_m(4, 1'b1, 32'h1234_5678, 3'd1);
        for (int c = 0; c < 5; c++) begin
            #1 check("t4_stall", {vo_m, ch_m, do_m, ready_m}, {1'b1, 3'd2, 32'hA5A5_A5A5, 8'h00});
            tick;
        end
        ro_m = 1'b1;
        #1 check("t4_rdy_resume", ready_m, 8'h10);
        tick;
        check("t4_out", {vo_m, ch_m, do_m}, {1'b1, 3'd4, 32'h1234_5678});
        set_m(4, 1'b0, 32'h0, 3'd0);

        // test 5: wrap-around on 5 channels, pointer still at reset value 4
        ro_5 = 1'b1;
        set_5(0, 1'b1, 32'h0000_00C0, 3'd3);
        set_5(4, 1'b1, 32'h0000_00C4, 3'd3);
        for (int c = 0; c < 3; c++) begin
            #1 check("t5_rdy", ready_5, 5'(1) << seq5[c]);
            tick;
            check("t5_out", {vo_5, ch_5, do_5}, {1'b1, 3'(seq5[c]), 32'h0000_00C0 + 32'(seq5[c])});
        end

        // test 6: aging
        reset = 1'b1;
        ro_a = 1'b1;
        set_a(0, 1'b1, 32'h0000_0AA0, 3'd0);
        set_a(5, 1'b1, 32'h0000_0AA5, 3'd7);
        #2 reset = 1'b0;
`ifdef PRIO_RR_ARBITER_AGING_EN
        for (int c = 1; c <= 5; c++) begin
            #1 check("t6_rdy", ready_a, (c == 5) ? 8'h01 : 8'h20);
            tick;
        end
        check("t6_aged_win", {vo_a, ch_a, do_a}, {1'b1, 3'd0, 32'h0000_0AA0});
        #1 check("t6_age_clear", ready_a, 8'h20);
        tick;
        check("t6_after", ch_a, 3'd5);
`else
        for (int c = 1; c <= 20; c++) begin
            #1 check("t6_no_age", ready_a, 8'h20);
            tick;
        end
        check("t6_last", {vo_a, ch_a}, {1'b1, 3'd5});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
